// File: rtl/ucode_pkg.sv
// Shared types and constants for the microprogram sequencer: next-state codes,
// FSM states, fetch address, RV32I opcodes and dispatch entry points.
package ucode_pkg;

    typedef enum logic [2:0] {
        NS_N   = 3'd0,
        NS_J   = 3'd1,
        NS_EZ  = 3'd2,
        NS_NZ  = 3'd3,
        NS_D   = 3'd4,
        NS_S   = 3'd5,
        NS_R6  = 3'd6,
        NS_R7  = 3'd7
    } ns_e;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [7:0] FETCH_ADDR = 8'h00;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [7:0] ENTRY_LUI    = 8'h20;
    localparam logic [7:0] ENTRY_AUIPC  = 8'h28;
    localparam logic [7:0] ENTRY_JAL    = 8'h30;
    localparam logic [7:0] ENTRY_JALR   = 8'h38;
    localparam logic [7:0] ENTRY_BRANCH = 8'h40;
    localparam logic [7:0] ENTRY_LOAD   = 8'h50;
    localparam logic [7:0] ENTRY_STORE  = 8'h60;
    localparam logic [7:0] ENTRY_OPIMM  = 8'h70;
    localparam logic [7:0] ENTRY_OP     = 8'h80;

endpackage

// File: rtl/ucode_dispatch.sv
// Combinational opcode -> microcode entry lookup; valid is low for opcodes
// outside the RV32I base set handled by the microcode.
module ucode_dispatch
    import ucode_pkg::*;
#(
    parameter int UPC_W = 8
) (
    input  logic [6:0]       opcode,
    output logic             valid,
    output logic [UPC_W-1:0] addr
);

    always_comb begin
        valid = 1'b1;
        addr  = '0;
        case (opcode)
            OPC_LUI:    addr = UPC_W'(ENTRY_LUI);
            OPC_AUIPC:  addr = UPC_W'(ENTRY_AUIPC);
            OPC_JAL:    addr = UPC_W'(ENTRY_JAL);
            OPC_JALR:   addr = UPC_W'(ENTRY_JALR);
            OPC_BRANCH: addr = UPC_W'(ENTRY_BRANCH);
            OPC_LOAD:   addr = UPC_W'(ENTRY_LOAD);
            OPC_STORE:  addr = UPC_W'(ENTRY_STORE);
            OPC_OPIMM:  addr = UPC_W'(ENTRY_OPIMM);
            OPC_OP:     addr = UPC_W'(ENTRY_OP);
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Micro-PC sequencer: addresses the microcode ROM and forwards its control word.
// Optional retired-dispatch counter enabled by `define UCODE_SEQ_INSTRET_EN.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int UPC_W  = 8,
    parameter int CTRL_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic                    zero,
    input  logic                    mem_busy,
    input  logic [CTRL_W+UPC_W+2:0] uinst,
    output logic [UPC_W-1:0]        upc,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic                    halted,
    output logic [31:0]             instret
);

    localparam int TOP = CTRL_W + UPC_W + 2;

    state_e           state;
    ns_e              ns;
    logic [UPC_W-1:0] target;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] next_upc;
    logic             disp_valid;
    logic [UPC_W-1:0] disp_addr;

    assign ns      = ns_e'(uinst[TOP -: 3]);
    assign target  = uinst[CTRL_W +: UPC_W];
    assign upc_inc = upc + UPC_W'(1);

    ucode_dispatch #(.UPC_W(UPC_W)) u_dispatch (
        .opcode (opcode),
        .valid  (disp_valid),
        .addr   (disp_addr)
    );

    always_comb begin
        next_upc = upc_inc;
        case (ns)
            NS_J:    next_upc = target;
            NS_EZ:   next_upc = zero ? target : upc_inc;
            NS_NZ:   next_upc = zero ? upc_inc : target;
            NS_D:    next_upc = disp_valid ? disp_addr : upc;
            NS_S:    next_upc = mem_busy ? upc : upc_inc;
            default: next_upc = upc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_RESET;
            upc    <= UPC_W'(FETCH_ADDR);
            halted <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_RUN;
                    upc   <= UPC_W'(FETCH_ADDR);
                end
                S_RUN: begin
                    // Illegal dispatch freezes upc where it is and parks the FSM.
                    if (ns == NS_D && !disp_valid) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        upc <= next_upc;
                    end
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_o = (state == S_RUN) ? uinst[CTRL_W-1:0] : '0;

`ifdef UCODE_SEQ_INSTRET_EN
    logic dispatch_fire;

    assign dispatch_fire = (state == S_RUN) && (ns == NS_D) && disp_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (dispatch_fire) begin
            instret <= instret + 32'd1;
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed scenarios followed by
// randomized microinstructions checked against a behavioural model.
module tb_ucode_sequencer;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_busy;
    logic [34:0] uinst;
    logic [7:0]  upc;
    logic [23:0] ctrl_o;
    logic        halted;
    logic [31:0] instret;

    ucode_sequencer #(.UPC_W(8), .CTRL_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .zero     (zero),
        .mem_busy (mem_busy),
        .uinst    (uinst),
        .upc      (upc),
        .ctrl_o   (ctrl_o),
        .halted   (halted),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: m_mode 0 = waiting for first edge after reset, 1 = running, 2 = halted.
    int      m_mode;
    int      m_upc;
    longint  m_count;

    int legal_ops[9]  = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                          7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    int entry_addr[9] = '{'h20, 'h28, 'h30, 'h38, 'h40, 'h50, 'h60, 'h70, 'h80};

    function automatic int lookup(input int opc);
        for (int i = 0; i < 9; i++)
            if (legal_ops[i] == opc) return entry_addr[i];
        return -1;
    endfunction

    function automatic logic [31:0] exp_instret();
`ifdef UCODE_SEQ_INSTRET_EN
        return 32'(m_count);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int ns, input int tgt, input bit z, input bit busy, input int opc);
        int inc;
        int d;
        inc = (m_upc + 1) % 256;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            case (ns)
                1: m_upc = tgt;
                2: m_upc = z ? tgt : inc;
                3: m_upc = z ? inc : tgt;
                4: begin
                    d = lookup(opc);
                    if (d < 0) m_mode = 2;
                    else begin
                        m_upc = d;
                        m_count = (m_count + 1) % 64'h1_0000_0000;
                    end
                end
                5: m_upc = busy ? m_upc : inc;
                default: m_upc = inc;
            endcase
        end
    endtask

    // Called at a negedge: apply one microinstruction, check ctrl, clock it, check state.
    task automatic step(input int ns, input int tgt, input int ctl, input bit z,
                        input bit busy, input int opc);
        uinst    = {3'(ns), 8'(tgt), 24'(ctl)};
        zero     = z;
        mem_busy = busy;
        opcode   = 7'(opc);
        #1;
        chk("ctrl_o", 32'(ctrl_o), (m_mode == 1) ? 32'(ctl & 'hFFFFFF) : 32'd0);
        @(posedge clk);
        model_edge(ns, tgt & 'hFF, z, busy, opc & 'h7F);
        @(negedge clk);
        chk("upc", 32'(upc), 32'(m_upc));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("instret", instret, exp_instret());
    endtask

    // Asynchronous reset asserted between edges, released at a negedge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_mode = 0; m_upc = 0; m_count = 0;
        chk("rst_upc", 32'(upc), 32'd0);
        chk("rst_ctrl", 32'(ctrl_o), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int ns, op;
        reset = 1'b0; opcode = '0; zero = 1'b0; mem_busy = 1'b0; uinst = '0;
        m_mode = 0; m_upc = 0; m_count = 0;
        do_reset();

        // Release: upc 0,0,1,2 and ctrl visible from the first running cycle.
        for (int i = 0; i < 4; i++) step(0, 0, 'hA5, 0, 0, 0);

        // EZ / NZ from upc 0x10 to target 0x40.
        step(1, 'h10, 'h111, 0, 0, 0);
        step(2, 'h40, 'h222, 1, 0, 0);
        chk("ez_taken", 32'(upc), 32'h40);
        step(1, 'h10, 'h111, 0, 0, 0);
        step(2, 'h40, 'h222, 0, 0, 0);
        chk("ez_fall", 32'(upc), 32'h11);
        step(1, 'h10, 'h111, 0, 0, 0);
        step(3, 'h40, 'h333, 1, 0, 0);
        chk("nz_fall", 32'(upc), 32'h11);
        step(1, 'h10, 'h111, 0, 0, 0);
        step(3, 'h40, 'h333, 0, 0, 0);
        chk("nz_taken", 32'(upc), 32'h40);

        // Dispatch LOAD.
        step(4, 'h00, 'h444, 0, 0, 7'b0000011);
        chk("load_entry", 32'(upc), 32'h50);

        // Spin at 0x22 for three busy cycles.
        step(1, 'h22, 'h555, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(5, 'h99, 'h5A5A5A, 0, 1, 0);
            chk("spin_hold", 32'(upc), 32'h22);
        end
        step(5, 'h99, 'h5A5A5A, 0, 0, 0);
        chk("spin_exit", 32'(upc), 32'h23);

        // Wrap-around, reserved codes.
        step(1, 'hFF, 'h666, 0, 0, 0);
        step(0, 'h00, 'h777, 0, 0, 0);
        chk("wrap", 32'(upc), 32'h00);
        step(6, 'h33, 'h888, 0, 0, 0);
        step(7, 'h33, 'h999, 0, 0, 0);

        // Illegal dispatch halts; upc frozen and ctrl gated while halted.
        step(4, 'h00, 'hABC, 0, 0, 7'b1111111);
        chk("halt_flag", 32'(halted), 32'd1);
        step(1, 'h77, 'hDEF, 0, 0, 0);
        step(4, 'h00, 'hDEF, 0, 0, 7'b0110011);
        do_reset();
        for (int i = 0; i < 2; i++) step(0, 0, 'h123, 0, 0, 0);

        // Randomized microinstructions.
        for (int i = 0; i < 400; i++) begin
            ns = int'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) op = int'($urandom_range(0, 127));
            else op = legal_ops[$urandom_range(0, 8)];
            step(ns, int'($urandom_range(0, 255)), int'($urandom_range(0, 'hFFFFFF)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
            if (m_mode == 2) begin
                step(0, 0, 'h1, 0, 0, 0);
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
